// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one unsigned eq/lt/gt comparator among N_REQ requesters.
// Grant one edge after req, tagged rsp_valid pulse one edge later; requesters hold req until served.
module cmp_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   a_in,
   input  logic [N_REQ*WIDTH-1:0]   b_in,
   output logic [N_REQ-1:0]         gnt,
   output logic                     busy,
   output logic                     rsp_valid,
   output logic [1:0]               rsp_id,
   output logic                     eq,
   output logic                     lt,
   output logic                     gt
);

   typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

   state_t             state_q;
   logic [N_REQ-1:0]   gnt_q;
   logic               rsp_valid_q;
   logic [1:0]         rsp_id_q;
   logic               eq_q, lt_q, gt_q;
   logic [WIDTH-1:0]   op_a_q, op_b_q;
   logic [1:0]         last_q;
   logic [1:0]         win_q;
   logic [1:0]         pick_d;

   // Scan from farthest to nearest so the requester right after last_q wins.
   always_comb begin
      pick_d = last_q;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[last_q + 2'(k)]) pick_d = last_q + 2'(k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 2'd0;
         eq_q        <= 1'b0;
         lt_q        <= 1'b0;
         gt_q        <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         last_q      <= 2'(N_REQ-1);
         win_q       <= 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_d;
                  win_q   <= pick_d;
                  op_a_q  <= a_in[pick_d*WIDTH +: WIDTH];
                  op_b_q  <= b_in[pick_d*WIDTH +: WIDTH];
                  state_q <= CMP;
               end
            end
            CMP: begin
               eq_q        <= (op_a_q == op_b_q);
               lt_q        <= (op_a_q <  op_b_q);
               gt_q        <= (op_a_q >  op_b_q);
               rsp_id_q    <= win_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               rsp_valid_q <= 1'b0;
               gnt_q       <= '0;
               last_q      <= win_q;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign eq        = eq_q;
   assign lt        = lt_q;
   assign gt        = gt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: expected responses queued at stimulus time, popped on rsp_valid.
module tb_cmp_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [2:0] flags;   // {eq, lt, gt}
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  a [4];
   logic [3:0]  b [4];
   logic [15:0] a_in, b_in;
   logic [3:0]  gnt;
   logic        busy, rsp_valid, eq, lt, gt;
   logic [1:0]  rsp_id;

   exp_t exp_q[$];
   int   rsp_cyc_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rsp_cnt = 0;
   int   cyc     = 0;
   int   n0;

   assign a_in = {a[3], a[2], a[1], a[0]};
   assign b_in = {b[3], b[2], b[1], b[0]};

   cmp_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .eq(eq), .lt(lt), .gt(gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [1:0] id, input logic [2:0] flags);
      exp_t e;
      e.id = id;
      e.flags = flags;
      exp_q.push_back(e);
   endtask

   // Scoreboard and structural invariants, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
         chk("busy_eq_gnt", busy, |gnt);
         if (rsp_valid) begin
            exp_t e;
            rsp_cnt++;
            rsp_cyc_q.push_back(cyc);
            chk("rsp_flags_onehot", 32'($onehot({eq, lt, gt})), 1);
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", rsp_id, e.id);
               chk("rsp_flags", {eq, lt, gt}, e.flags);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req   = 4'b0;
      for (int i = 0; i < 4; i++) begin a[i] = 4'h0; b[i] = 4'h0; end
      repeat (2) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_vld", rsp_valid, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_flags", {eq, lt, gt}, 0);
      rst_n = 1'b1;

      // Single requester 0: lt
      @(negedge clk); a[0] = 4'b0110; b[0] = 4'b0111; req = 4'b0001; push(2'd0, 3'b010);
      @(negedge clk);
      chk("t1_gnt", gnt, 4'b0001);
      chk("t1_busy", busy, 1);
      chk("t1_no_vld_yet", rsp_valid, 0);
      @(negedge clk);
      chk("t1_vld", rsp_valid, 1);
      req = 4'b0;
      @(negedge clk);
      chk("t1_gnt_clr", gnt, 0);
      chk("t1_busy_clr", busy, 0);
      chk("t1_vld_clr", rsp_valid, 0);

      // Single requester 2: eq, exactly one pulse
      @(negedge clk); a[2] = 4'b0111; b[2] = 4'b0111; req = 4'b0100; push(2'd2, 3'b100);
      n0 = rsp_cnt;
      repeat (2) @(negedge clk);
      req = 4'b0;
      repeat (4) @(negedge clk);
      chk("t2_one_pulse", rsp_cnt - n0, 1);

      // Reset pointer, then all four held for 12 cycles
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      a[0] = 4'h2; b[0] = 4'h9; push(2'd0, 3'b010);
      a[1] = 4'h5; b[1] = 4'h5; push(2'd1, 3'b100);
      a[2] = 4'h9; b[2] = 4'h1; push(2'd2, 3'b001);
      a[3] = 4'h0; b[3] = 4'hF; push(2'd3, 3'b010);
      rsp_cyc_q.delete();
      req = 4'b1111;
      repeat (12) @(negedge clk);
      req = 4'b0;
      repeat (3) @(negedge clk);
      chk("t3_rsp_count", rsp_cyc_q.size(), 4);
      if (rsp_cyc_q.size() == 4)
         for (int i = 1; i < 4; i++) chk("t3_rsp_spacing", rsp_cyc_q[i] - rsp_cyc_q[i-1], 3);

      // Serve 1, then 1010 must go to 3 before 1
      @(negedge clk); a[1] = 4'h3; b[1] = 4'h8; req = 4'b0010; push(2'd1, 3'b010);
      repeat (2) @(negedge clk);
      req = 4'b0;
      repeat (2) @(negedge clk);
      a[3] = 4'hC; b[3] = 4'h4; push(2'd3, 3'b001);
      a[1] = 4'h1; b[1] = 4'h1; push(2'd1, 3'b100);
      req = 4'b1010;
      @(negedge clk);
      chk("t4_gnt3_first", gnt, 4'b1000);
      repeat (3) @(negedge clk);
      chk("t4_gnt1_next", gnt, 4'b0010);
      repeat (2) @(negedge clk);
      req = 4'b0;
      @(negedge clk);

      // Operands and req change after grant: in-flight compare unaffected
      @(negedge clk); a[3] = 4'hF; b[3] = 4'h0; req = 4'b1000; push(2'd3, 3'b001);
      @(negedge clk);
      chk("t5_gnt", gnt, 4'b1000);
      req = 4'b0; a[3] = 4'h0;
      @(negedge clk);
      chk("t5_vld", rsp_valid, 1);
      repeat (2) @(negedge clk);

      // Reset during CMP: outputs clear at once, response lost, pointer back to 3
      @(negedge clk); a[1] = 4'h2; b[1] = 4'h9; req = 4'b0010;
      @(negedge clk);
      chk("t6_gnt_pre", gnt, 4'b0010);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_gnt", gnt, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_flags", {eq, lt, gt}, 0);
      chk("t6_rst_vld", rsp_valid, 0);
      n0 = rsp_cnt;
      @(negedge clk);
      a[0] = 4'h4; b[0] = 4'h4; push(2'd0, 3'b100);
      push(2'd1, 3'b010);
      req = 4'b0011;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_gnt0_first", gnt, 4'b0001);
      repeat (5) @(negedge clk);
      req = 4'b0;
      repeat (3) @(negedge clk);
      chk("t6_rsp_count", rsp_cnt - n0, 2);
      chk("sb_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Round-robin scheduler that shares one 4-bit ALU equality/magnitude comparator among N_REQ requesters.
- Each requester presents an operand pair and holds a request.
- The block grants one requester, latches its operands, evaluates eq/lt/gt, and returns a tagged one-cycle response.
- Sits between the ALU comparator datapath and its client units.

Parameters:
- N_REQ, 4, number of requesters (fixed at 4; rsp_id is 2 bits).
- WIDTH, 4, operand width in bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous reset, active low.
- req  input  N_REQ  per-requester request, level; held until rsp_valid with matching rsp_id.
- a_in  input  N_REQ*WIDTH  operand A; requester i uses a_in[i*WIDTH +: WIDTH].
- b_in  input  N_REQ*WIDTH  operand B, same packing as a_in.
- gnt  output  N_REQ  one-hot grant, registered; high for the whole service.
- busy  output  1  high whenever state is not IDLE.
- rsp_valid  output  1  one-cycle pulse; result valid.
- rsp_id  output  2  index of the serviced requester.
- eq  output  1  A == B.
- lt  output  1  A < B, unsigned.
- gt  output  1  A > B, unsigned.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - gnt=0, busy=0, rsp_valid=0, rsp_id=0, eq=lt=gt=0.
  - Operand latches cleared to 0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, CMP, RESP.
  - IDLE: if req!=0 at the clock edge, then at that edge:
    - select the winner by searching from (last+1) mod N_REQ upward, with wrap-around;
    - gnt <= one-hot(winner);
    - latch a_in/b_in slices of the winner into op_a/op_b;
    - state <= CMP.
  - IDLE with req==0: stay in IDLE; gnt stays 0.
  - CMP: at the edge, compute from the latched operands only:
    - eq <= (op_a==op_b);
    - lt <= (op_a<op_b);
    - gt <= (op_a>op_b);
    - rsp_id <= winner;
    - rsp_valid <= 1;
    - state <= RESP.
  - RESP: rsp_valid is high during this cycle. At the edge:
    - rsp_valid <= 0;
    - gnt <= 0;
    - last <= winner;
    - state <= IDLE.
- Latency and throughput:
  - The request is sampled at edge E0; rsp_valid is high in the cycle after E1 and drops at E2.
  - Maximum throughput is one compare per 3 cycles, with a mandatory IDLE cycle between services.
- Exactly one of eq/lt/gt is 1 after any response.
- eq/lt/gt/rsp_id hold their last value until the next response; a consumer samples them only with rsp_valid=1.
- Operand changes on a_in/b_in after the grant edge have no effect on the in-flight compare.
- A requester dropping req during CMP/RESP:
  - the operation still completes and rsp_valid still pulses;
  - the pointer still advances.
- Simultaneous requests: exactly one grant, chosen by the rotating priority. Pointer update order:
  - all four held continuously → 0,1,2,3,0,...;
  - a requester is never granted twice in a row while another req bit is set.
- Reset mid-operation (CMP or RESP):
  - all outputs clear immediately with no clock edge;
  - the in-flight response is lost, and no rsp_valid is produced after release;
  - the pointer returns to N_REQ-1.
- Comparison is unsigned over WIDTH bits; no carry or overflow outputs.

Test Plan:
- Only req[0]=1, a0=4'b0110, b0=4'b0111 → after E0 gnt=0001, busy=1; after E1 rsp_valid=1, rsp_id=0, eq=0, lt=1, gt=0; after E2 gnt=0, busy=0.
- Only req[2]=1, a2=4'b0111, b2=4'b0111 → rsp_id=2, eq=1, lt=0, gt=0; one rsp_valid pulse only.
- req=4'b1111 held for 12 cycles with distinct operands → rsp_id sequence 0,1,2,3; each rsp_valid is 3 cycles apart; gnt is always one-hot or zero.
- Service requester 1 first, then req=4'b1010 → requester 3 is granted before 1; next grant is 1.
- req[3]=1, a3=4'hF, b3=4'h0, then drop req[3] and change a3 to 0 during CMP → response still arrives with rsp_id=3, gt=1.
- Assert rst_n=0 mid-CMP with req[1] pending → gnt, busy and eq/lt/gt go to 0 immediately, no rsp_valid; after release with req=4'b0011, requester 0 is granted first.
